// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Shares one single-port video RAM (16-bit word, two byte banks: bank0 = [7:0],
//   bank1 = [15:8]) between the 6502 bus (byte reads/writes) and the video
//   scan-out fetcher (16-bit word reads).
//
//   Video normally wins arbitration. A wait counter bounds how many consecutive
//   cycles a pending CPU request may lose to video; once it reaches MAX_WAIT the
//   CPU is forced through for one cycle. MAX_WAIT = 0 means the CPU always wins.
//
//   Two-stage operation:
//     ISSUE  (cycle N)   : grant decided combinationally, ram_* registered.
//     RETURN (cycle N+1) : cpu_ack / vid_valid pulse, read data from ram_rdata.
//   The RAM presents ram_rdata for the registered ram_addr during the RETURN
//   cycle, so the read data outputs pass ram_rdata through in that cycle and
//   hold the captured value afterwards.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU byte request (level, held until cpu_ack);
//                         cpu_addr[0] selects the bank, [AW:1] the word
//   cpu_rdata, cpu_ack    read byte and one-cycle completion pulse
//   vid_req, vid_addr     video word request (level) and word address
//   vid_gnt               video request accepted this cycle (combinational)
//   vid_rdata, vid_valid  video word and one-cycle valid pulse (gnt + 1)
//   ram_addr/we/wdata     registered RAM controls (per-bank write enables)
//   ram_rdata             RAM read word for the address issued last cycle
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int AW       = 14,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic [15:0]   vid_rdata,
  output logic          vid_valid,
  output logic [AW-1:0] ram_addr,
  output logic [1:0]    ram_we,
  output logic [15:0]   ram_wdata,
  input  logic [15:0]   ram_rdata
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  // Per-bank write enable for a byte write: odd byte address -> bank1.
  function automatic logic [1:0] lane_we(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  // Byte extraction from a RAM word, same bank mapping as lane_we.
  function automatic logic [7:0] lane_rd(input logic [15:0] word, input logic sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

  logic [WCW-1:0] wait_cnt;
  logic           cpu_busy;

  logic           cpu_pend_p0;
  logic           wait_full_p0;
  logic           cpu_gnt_p0;
  logic           vid_gnt_p0;

  logic           cpu_rd_p1;
  logic           cpu_sel_p1;
  logic           vld_p1;
  logic           cpu_rd_vld_p1;

  logic [7:0]     cpu_rdata_q;
  logic [15:0]    vid_rdata_q;

  // ---- ISSUE stage: arbitration ----
  // cpu_busy is high exactly in the CPU RETURN cycle, so a cpu_req still held
  // during the ack cycle is not seen as a new request. Grants are gated with
  // rst_n so vid_gnt reads 0 while reset is asserted.
  always_comb begin
    cpu_pend_p0  = cpu_req & ~cpu_busy;
    wait_full_p0 = (wait_cnt == WAIT_MAX);
    cpu_gnt_p0   = rst_n & cpu_pend_p0 & (~vid_req | wait_full_p0);
    vid_gnt_p0   = rst_n & vid_req & ~cpu_gnt_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!cpu_req || cpu_gnt_p0) begin
      wait_cnt <= '0;
    end else if (cpu_pend_p0 && vid_gnt_p0 && !wait_full_p0) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // RAM controls. ram_addr holds when idle; ram_wdata only changes on writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_we    <= 2'b00;
      ram_wdata <= '0;
    end else if (cpu_gnt_p0) begin
      ram_addr <= cpu_addr[AW:1];
      ram_we   <= cpu_we ? lane_we(cpu_addr[0]) : 2'b00;
      if (cpu_we) begin
        ram_wdata <= {cpu_wdata, cpu_wdata};
      end
    end else if (vid_gnt_p0) begin
      ram_addr <= vid_addr;
      ram_we   <= 2'b00;
    end else begin
      ram_we   <= 2'b00;
    end
  end

  // ---- RETURN stage: completion flags and read data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_busy   <= 1'b0;
      cpu_rd_p1  <= 1'b0;
      cpu_sel_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      cpu_busy  <= cpu_gnt_p0;
      cpu_rd_p1 <= cpu_gnt_p0 & ~cpu_we;
      vld_p1    <= vid_gnt_p0;
      if (cpu_gnt_p0) begin
        cpu_sel_p1 <= cpu_addr[0];
      end
    end
  end

  assign cpu_rd_vld_p1 = cpu_busy & cpu_rd_p1;

  // Held copies so the read outputs keep the last returned value; CPU writes
  // never touch cpu_rdata_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      if (cpu_rd_vld_p1) begin
        cpu_rdata_q <= lane_rd(ram_rdata, cpu_sel_p1);
      end
      if (vld_p1) begin
        vid_rdata_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    vid_gnt   = vid_gnt_p0;
    cpu_ack   = cpu_busy;
    vid_valid = vld_p1;
    cpu_rdata = cpu_rd_vld_p1 ? lane_rd(ram_rdata, cpu_sel_p1) : cpu_rdata_q;
    vid_rdata = vld_p1 ? ram_rdata : vid_rdata_q;
  end

endmodule
